muxn_rr: RTL
============

Name: muxn_rr

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the 4-bit 2:1 combinational mux. Adds a channel count parameter, a data width parameter, one output register stage and two selection modes: fixed select and round-robin arbitration.
- Used to merge several producer streams onto one datapath bus.

Parameters:
- W, 4, data width per channel in bits (W >= 1).
- N, 4, number of input channels (2 <= N <= 16).
- SW, 2, select/pointer width in bits; the instantiator must ensure 2**SW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via s; 1 = round-robin over in_valid.
- s  input  SW  channel select, used only when mode = 0.
- in_data  input  N*W  flattened inputs; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational.
- out_data  output  W  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream accept.
- out_sel  output  SW  index of the channel whose data is held in out_data.

Behaviour:
- Reset values on a clk edge with reset = 1: out_data = 0, out_valid = 0, out_sel = 0, round-robin pointer ptr = N-1, so channel 0 has first priority. Reset overrides all other activity. Held data is discarded and no in_ready is asserted in that cycle.
- Load enable: ld = ~out_valid | out_ready. This is combinational and gives full throughput, one transfer per cycle.
- Grant in mode 0:
  - gnt = s when in_valid[s] = 1 and s < N.
  - Otherwise there is no grant. An out-of-range s never grants.
- Grant in mode 1:
  - Scan channels ptr+1, ptr+2, ... with wrap-around modulo N.
  - The first channel with in_valid = 1 wins. If no channel is valid, there is no grant.
- in_ready[i] = ld & grant_valid & (gnt == i). At most one bit is set in any cycle.
- Register update on a clk edge when ld = 1:
  - If grant_valid: out_data <= channel gnt data, out_sel <= gnt, out_valid <= 1.
  - Otherwise: out_valid <= 0. out_data and out_sel hold their values.
- When ld = 0, all output registers hold their values (stall). in_ready stays all-zero during a stall.
- Latency: an input accepted at edge k appears on out_data after edge k, one cycle.
- Pointer update:
  - ptr <= gnt only on an accepted transfer in mode 1.
  - In mode 0, ptr holds its value.
  - Switching mode takes effect for the grant in the same cycle. ptr is kept across mode switches.
- Wrap-around example: with ptr = N-1, channel 0 is checked first. With ptr = 2 and N = 4, the order is 3, 0, 1, 2.
- Simultaneous drain and refill: out_valid = 1, out_ready = 1 and a grant present gives a new load at that edge with no bubble.
- Producers may drop in_valid freely. No grant decision is stored between cycles, apart from lock under the optional feature below.

Optional Feature:
- Macro: MUXN_LOCK_EN.
- Defined:
  - Adds input in_last [N].
  - In mode 1, after channel g is accepted with in_last[g] = 0, the arbiter locks onto g.
  - While locked, only g can be granted, even if other channels are valid.
  - The lock releases when a transfer from g with in_last[g] = 1 is accepted, on reset, or when mode = 0.
  - ptr updates only on that releasing transfer.
- Not defined: the in_last port is absent and there is no locking. Every accepted transfer is arbitrated independently.

Test Plan (W=4, N=4):
- Reset: assert reset for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0000 throughout.
- Fixed select: mode = 0, s = 2, channel 2 data = 4'b1010 valid, out_ready = 1 -> in_ready = 0100; next cycle out_data = 1010, out_sel = 2, out_valid = 1. Then s = 3 with in_valid[3] = 0 -> out_valid = 0 next cycle.
- Round-robin fairness: mode = 1, in_valid = 1111, channel data 1,2,3,4, out_ready = 1 -> out_sel sequence 0,1,2,3,0, out_data 1,2,3,4,1, no bubbles.
- Stall/backpressure: out_valid = 1 holding 4'b0011, out_ready = 0 for 3 cycles while in_valid = 1111 -> out_data stays 0011, in_ready = 0000. out_ready = 1 -> next channel is loaded in the same edge.
- Sparse wrap: mode = 1, ptr = 2, in_valid = 0011 -> grant 0, then 1, then 0. Reset mid-stream -> out_valid = 0 and channel 0 has priority again.
- MUXN_LOCK_EN: ch1 sends 3 beats with in_last = 0,0,1 while ch0 and ch2 are valid -> out_sel = 1,1,1, then 2.

Source files
------------

// File: rtl/muxn_rr.sv
// N-input, W-bit registered multiplexer with valid/ready handshakes, fixed-select or round-robin.
// Optional packet locking in round-robin mode is enabled by defining MUXN_LOCK_EN.
module muxn_rr #(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
`ifdef MUXN_LOCK_EN
  input  logic [N-1:0]   in_last,
`endif
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);

  // Pointer starts at the last channel so channel 0 is scanned first.
  localparam logic [SW-1:0] PTR_RST = SW'(N - 1);

  logic [SW-1:0] ptr;
  logic          ld;
  logic          accept;
  logic          fix_ok;
  logic [SW-1:0] fix_gnt;
  logic          rr_ok;
  logic [SW-1:0] rr_gnt;
  logic          gnt_ok;
  logic [SW-1:0] gnt;
  logic [W-1:0]  gnt_data;

  assign ld     = ~out_valid | out_ready;
  assign accept = ld & gnt_ok & ~reset;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fix_ok  = 1'b0;
    fix_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (s == SW'(i) && in_valid[i]) begin
        fix_ok  = 1'b1;
        fix_gnt = SW'(i);
      end
    end
  end

  // Rotating priority as two ascending passes: channels above ptr, then the rest.
  always_comb begin
    rr_ok  = 1'b0;
    rr_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (!rr_ok && in_valid[i] && SW'(i) > ptr) begin
        rr_ok  = 1'b1;
        rr_gnt = SW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rr_ok && in_valid[i] && SW'(i) <= ptr) begin
        rr_ok  = 1'b1;
        rr_gnt = SW'(i);
      end
    end
  end

`ifdef MUXN_LOCK_EN
  logic          lock_q;
  logic [SW-1:0] lock_ch;
  logic          lock_ok;
  logic          gnt_last;

  always_comb begin
    lock_ok  = 1'b0;
    gnt_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (lock_ch == SW'(i) && in_valid[i]) lock_ok = 1'b1;
      if (gnt == SW'(i)) gnt_last = in_last[i];
    end
  end
`endif

  always_comb begin
    gnt_ok = fix_ok;
    gnt    = fix_gnt;
    if (mode) begin
`ifdef MUXN_LOCK_EN
      if (lock_q) begin
        gnt_ok = lock_ok;
        gnt    = lock_ch;
      end else begin
        gnt_ok = rr_ok;
        gnt    = rr_gnt;
      end
`else
      gnt_ok = rr_ok;
      gnt    = rr_gnt;
`endif
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SW'(i)) gnt_data = in_data[i*W +: W];
      in_ready[i] = accept && (gnt == SW'(i));
    end
  end

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (ld) begin
      out_valid <= gnt_ok;
      if (gnt_ok) begin
        out_data <= gnt_data;
        out_sel  <= gnt;
      end
    end
  end

`ifdef MUXN_LOCK_EN
  // A non-last beat in round-robin mode pins the arbiter to that channel until its last beat.
  always_ff @(posedge clk) begin
    if (reset || !mode) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      lock_q  <= ~gnt_last;
      lock_ch <= gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= PTR_RST;
    else if (accept && mode && gnt_last) ptr <= gnt;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) ptr <= PTR_RST;
    else if (accept && mode) ptr <= gnt;
  end
`endif

endmodule
